// File: rtl/lsu_axil_bridge_pkg.sv
// Shared definitions for the LSU bus bridge and its lane aligner:
// LSU op encodings, bridge FSM states, AXI response codes and the
// base write-strobe helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B   = 3'b000,
    LSU_H   = 3'b001,
    LSU_W   = 3'b010,
    LSU_D   = 3'b011,
    LSU_BU  = 3'b100,
    LSU_HU  = 3'b101,
    LSU_WU  = 3'b110,
    LSU_ILL = 3'b111
  } lsu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AWW  = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // Byte-enable mask for an access of 2**size bytes starting at lane 0.
  function automatic logic [7:0] base_strb(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment between LSU-side (LSB-aligned) data and a
// 64-bit bus word.
//   op       : LSU op encoding (size in op[1:0], unsigned load in op[2])
//   offs     : byte offset within the bus word (addr[2:0])
//   st_data  : store data, LSB-aligned
//   st_wdata : store data shifted onto its byte lanes
//   st_wstrb : byte strobes for the store
//   ld_bus   : raw bus read word
//   ld_data  : load result shifted down and sign/zero-extended
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [2:0]  offs,
  input  logic [63:0] st_data,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wstrb,
  input  logic [63:0] ld_bus,
  output logic [63:0] ld_data
);

  logic [5:0]  sh_amt;
  logic [63:0] ld_sh;

  assign sh_amt = {offs, 3'b000};

  always_comb begin
    st_wdata = st_data << sh_amt;
    st_wstrb = base_strb(op[1:0]) << offs;
    ld_sh    = ld_bus >> sh_amt;
    ld_data  = ld_sh;
    case (op)
      LSU_B:   ld_data = {{56{ld_sh[7]}},  ld_sh[7:0]};
      LSU_H:   ld_data = {{48{ld_sh[15]}}, ld_sh[15:0]};
      LSU_W:   ld_data = {{32{ld_sh[31]}}, ld_sh[31:0]};
      LSU_BU:  ld_data = {56'd0, ld_sh[7:0]};
      LSU_HU:  ld_data = {48'd0, ld_sh[15:0]};
      LSU_WU:  ld_data = {32'd0, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu_axil_bridge.sv
// Bridges single load/store requests from the LSU onto an AXI4-Lite master.
//   clk, rst            : clock, asynchronous active-low reset
//   req_*               : request handshake (we, op, byte addr, LSB-aligned wdata)
//   resp_*              : response handshake (extended load data, error flag)
//   aw*/w*/b*/ar*/r*    : AXI4-Lite master channels, 8-byte aligned addresses
module lsu_axil_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [7:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  aw_done_q, w_done_q;
  logic                  misal, req_bad;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    misal = 1'b0;
    case (req_op[1:0])
      2'd1:    misal = req_addr[0];
      2'd2:    misal = |req_addr[1:0];
      2'd3:    misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
    req_bad = (req_op == LSU_ILL) || (req_we && req_op[2]) || misal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = req_bad ? S_DONE : (req_we ? S_AWW : S_AR);
      S_AR:   if (arready)   state_d = S_R;
      S_R:    if (rvalid)    state_d = S_DONE;
      // Leave on the edge that completes the last outstanding handshake, so
      // B is the first cycle in which both are done.
      S_AWW:  if ((aw_done_q || awready) && (w_done_q || wready)) state_d = S_B;
      S_B:    if (bvalid)     state_d = S_DONE;
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q      <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          we_q      <= req_we;
          op_q      <= req_op;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          err_q     <= req_bad;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        S_R: if (rvalid) begin
          rdata_q <= rdata;
          err_q   <= (rresp == AXI_SLVERR) || (rresp == AXI_DECERR);
        end
        S_AWW: begin
          if (awvalid && awready) aw_done_q <= 1'b1;
          if (wvalid && wready)   w_done_q  <= 1'b1;
        end
        S_B: if (bvalid) err_q <= (bresp == AXI_SLVERR) || (bresp == AXI_DECERR);
        default: ;
      endcase
    end
  end

  lsu_lane_align u_align (
    .op       (op_q),
    .offs     (addr_q[2:0]),
    .st_data  (wdata_q),
    .st_wdata (wdata),
    .st_wstrb (wstrb),
    .ld_bus   (rdata_q),
    .ld_data  (ld_data)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign arvalid    = (state_q == S_AR);
  assign rready     = (state_q == S_R);
  assign awvalid    = (state_q == S_AWW) && !aw_done_q;
  assign wvalid     = (state_q == S_AWW) && !w_done_q;
  assign bready     = (state_q == S_B);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = (state_q == S_DONE) && err_q;
  assign resp_rdata = ((state_q == S_DONE) && !we_q && !err_q) ? ld_data : '0;
  assign araddr     = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign awaddr     = {addr_q[ADDR_WIDTH-1:3], 3'b000};

endmodule

// File: tb/tb_lsu_axil_bridge.sv
module tb_lsu_axil_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  lsu_axil_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic        e;
    int          lat;
    int          t0;
  } exp_t;
  exp_t exp_q[$];

  // Slave configuration and observation log
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;
  int          cfg_w_delay = 0;
  bit          cfg_hold_aw = 0;
  bit          cfg_hold_w = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          arv_cycles = 0, awv_cycles = 0;
  logic [63:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [7:0]  last_wstrb = '0;
  int          w_fire_cyc = -1, first_bready_cyc = -1;

  // AXI4-Lite slave: decides readies at the negedge for the current cycle,
  // and applies handshake consequences one cycle later.
  initial begin
    bit ar_f, r_f, aw_f, w_f, b_f, aw_got, w_got;
    int w_wait;
    ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0; aw_got = 0; w_got = 0; w_wait = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0; aw_got = 0; w_got = 0; w_wait = 0;
      end else begin
        if (r_f) rvalid = 0;
        if (ar_f) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end
        if (b_f) bvalid = 0;
        if (aw_f) aw_got = 1;
        if (w_f) w_got = 1;
        if (aw_got && w_got) begin bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0; end
        arready = arvalid;
        awready = awvalid && !cfg_hold_aw;
        if (!wvalid) w_wait = 0;
        wready = wvalid && !cfg_hold_w && (w_wait >= cfg_w_delay);
        if (wvalid && !wready) w_wait++;
        if (arvalid) arv_cycles++;
        if (awvalid) awv_cycles++;
        if (bready && first_bready_cyc < 0) first_bready_cyc = int'(cyc);
        ar_f = arvalid && arready;
        r_f  = rvalid && rready;
        aw_f = awvalid && awready;
        w_f  = wvalid && wready;
        b_f  = bvalid && bready;
        if (ar_f) begin ar_cnt++; last_araddr = araddr; end
        if (aw_f) begin aw_cnt++; last_awaddr = awaddr; end
        if (w_f) begin w_cnt++; last_wdata = wdata; last_wstrb = wstrb; w_fire_cyc = int'(cyc); end
        if (b_f) b_cnt++;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    bit   in_resp;
    exp_t e;
    in_resp = 0;
    forever begin
      @(negedge clk);
      if (rst && resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_resp: got rdata 0x%h err %0b, required no response", resp_rdata, resp_err);
          end else if (exp_q[0].lat > 0) begin
            chk("resp_latency", 64'(int'(cyc) - exp_q[0].t0), 64'(exp_q[0].lat));
          end
        end
        if (resp_ready) begin
          in_resp = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.d);
            chk("resp_err", {63'd0, resp_err}, {63'd0, e.e});
          end
        end
      end else begin
        in_resp = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_d, input logic exp_e,
                       input int lat, input bit push);
    int t;
    exp_t e;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL req_ready_timeout: got req_ready 0, required 1");
    end
    req_valid = 1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    if (push) begin
      e.d = exp_d; e.e = exp_e; e.lat = lat; e.t0 = int'(cyc);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] bus,
                         input logic [1:0] rr, input logic [63:0] exp_d, input logic exp_e, input int lat);
    cfg_rdata = bus; cfg_rresp = rr;
    issue(1'b0, op, addr, '0, exp_d, exp_e, lat, 1);
    wait_empty();
  endtask

  task automatic do_store(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [1:0] br, input logic exp_e, input int lat);
    cfg_bresp = br;
    issue(1'b1, op, addr, wd, 64'd0, exp_e, lat, 1);
    wait_empty();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, b0, av0;
    req_valid = 0; req_we = 0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 1;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_axi_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
    rst = 1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    // loads
    do_load(3'b011, 64'h80000008, 64'h1122334455667788, 2'b00, 64'h1122334455667788, 0, 3);
    chk("ld_araddr", last_araddr, 64'h80000008);
    do_load(3'b000, 64'h80000003, 64'h0000000080FF0000, 2'b00, 64'hFFFFFFFFFFFFFF80, 0, 3);
    chk("lb_araddr", last_araddr, 64'h80000000);
    do_load(3'b100, 64'h80000003, 64'h0000000080FF0000, 2'b00, 64'h0000000000000080, 0, 3);
    do_load(3'b001, 64'h80000002, 64'h0000000080FF0000, 2'b00, 64'hFFFFFFFFFFFF80FF, 0, 3);
    do_load(3'b101, 64'h80000002, 64'h0000000080FF0000, 2'b00, 64'h00000000000080FF, 0, 3);
    do_load(3'b010, 64'h80000004, 64'h89ABCDEF00000000, 2'b00, 64'hFFFFFFFF89ABCDEF, 0, 3);
    do_load(3'b110, 64'h80000004, 64'h89ABCDEF00000000, 2'b00, 64'h0000000089ABCDEF, 0, 3);

    // sh with wready delayed 3 cycles after awready
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; first_bready_cyc = -1; cfg_w_delay = 3;
    do_store(3'b001, 64'h80000006, 64'h000000000000ABCD, 2'b00, 0, 0);
    cfg_w_delay = 0;
    chk("sh_wstrb", {56'd0, last_wstrb}, 64'h00000000000000C0);
    chk("sh_wdata", last_wdata, 64'hABCD000000000000);
    chk("sh_awaddr", last_awaddr, 64'h80000000);
    chk("sh_aw_count", 64'(aw_cnt - a0), 64'd1);
    chk("sh_w_count", 64'(w_cnt - w0), 64'd1);
    chk("sh_b_count", 64'(b_cnt - b0), 64'd1);
    chk("sh_b_after_w", 64'(first_bready_cyc - w_fire_cyc), 64'd1);

    // zero-wait stores
    do_store(3'b011, 64'h80000010, 64'h0123456789ABCDEF, 2'b00, 0, 3);
    chk("sd_wstrb", {56'd0, last_wstrb}, 64'h00000000000000FF);
    chk("sd_wdata", last_wdata, 64'h0123456789ABCDEF);
    chk("sd_awaddr", last_awaddr, 64'h80000010);
    do_store(3'b000, 64'h80000005, 64'h000000000000005A, 2'b00, 0, 3);
    chk("sb_wstrb", {56'd0, last_wstrb}, 64'h0000000000000020);
    chk("sb_wdata", last_wdata, 64'h00005A0000000000);

    // misaligned / illegal: no bus activity, response next cycle
    av0 = arv_cycles;
    do_load(3'b010, 64'h80000002, 64'hDEADBEEFDEADBEEF, 2'b00, 64'd0, 1, 1);
    do_load(3'b111, 64'h80000000, 64'hDEADBEEFDEADBEEF, 2'b00, 64'd0, 1, 1);
    do_load(3'b011, 64'h80000004, 64'hDEADBEEFDEADBEEF, 2'b00, 64'd0, 1, 1);
    chk("bad_load_no_arvalid", 64'(arv_cycles - av0), 64'd0);
    av0 = awv_cycles;
    do_store(3'b100, 64'h80000000, 64'h00000000000000FF, 2'b00, 1, 1);
    chk("bad_store_no_awvalid", 64'(awv_cycles - av0), 64'd0);

    // SLVERR read with response back-pressure
    resp_ready = 0;
    cfg_rdata = 64'hCAFEF00DCAFEF00D; cfg_rresp = 2'b10;
    issue(1'b0, 3'b011, 64'h80000000, '0, 64'd0, 1, 3, 1);
    begin
      int t;
      t = 0;
      while (!resp_valid && t < 20) begin @(posedge clk); #1; t++; end
    end
    for (int i = 0; i < 4; i++) begin
      chk("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("stall_resp_rdata", resp_rdata, 64'd0);
      chk("stall_resp_err", {63'd0, resp_err}, 64'd1);
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    wait_empty();
    cfg_rresp = 2'b00;

    // DECERR write
    do_store(3'b010, 64'h80000000, 64'h0000000012345678, 2'b11, 1, 3);
    cfg_bresp = 2'b00;

    // reset while awvalid is pending
    cfg_hold_aw = 1; cfg_hold_w = 1;
    issue(1'b1, 3'b010, 64'h80000020, 64'h00000000AAAA5555, 64'd0, 0, 0, 0);
    chk("aww_awvalid_before_rst", {63'd0, awvalid}, 64'd1);
    #2 rst = 0;
    #1;
    chk("rst_mid_awvalid", {63'd0, awvalid}, 64'd0);
    chk("rst_mid_wvalid", {63'd0, wvalid}, 64'd0);
    @(posedge clk); #1;
    rst = 1; cfg_hold_aw = 0; cfg_hold_w = 0;
    @(posedge clk); #1;
    chk("rst_mid_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_mid_resp_valid", {63'd0, resp_valid}, 64'd0);
    do_load(3'b011, 64'h80000018, 64'h0F0E0D0C0B0A0908, 2'b00, 64'h0F0E0D0C0B0A0908, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
